// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default sizing constants and a small index-width helper.
// No ports (package).
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_t;

  localparam int DEFAULT_NREQ        = 4;
  localparam int DEFAULT_TIMEOUT_CYC = 26042;

  // Cycles WAIT_HI tolerates before giving up on seeing tx_busy rise.
  localparam int WAIT_HI_CYC = 4;

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester handshake and the UART transmitter handshake.
//   req_valid/req_data/req_last : per-requester byte offer (8 bits per requester)
//   req_ready                   : one-hot byte-accepted strobe
//   grant                       : one-hot current owner
//   tx_data/tx_start            : byte and launch pulse to the UART transmitter
//   tx_busy                     : UART transmitter is shifting a frame
//   timeout_err                 : owner stalled mid-packet
// Modports: master = requesters + UART side, slave = arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              timeout_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_start, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_start, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector: returns the first requester at or
// after ptr (wrapping cyclically) whose request bit is set.
//   req  : request vector
//   ptr  : starting index (0..NREQ-1)
//   pick : one-hot winner, all-zero when no request
//   idx  : index of the winner (0 when no request)
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);

  // Scan offsets from the farthest to the nearest so the requester closest
  // to ptr is the last one written and therefore wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == ((int'(ptr) + k) % NREQ))) begin
          pick    = '0;
          pick[j] = 1'b1;
          idx     = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NREQ packet sources. A requester is
// granted for a whole packet (until its req_last byte has been shifted out)
// or until it stalls for TIMEOUT_CYC cycles; owners rotate round-robin.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : uart_tx_arbiter_if.slave (requester and UART handshakes)
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ        = DEFAULT_NREQ,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int WW = 3;

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [NREQ-1:0] grant_r, grant_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [7:0]      tx_data_r, tx_data_nxt;
  logic            tx_start_r, tx_start_nxt;
  logic            last_flag, last_flag_nxt;
  logic [CW-1:0]   stall_cnt, stall_cnt_nxt;
  logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            timeout_r, timeout_nxt;
  logic [NREQ-1:0] ready_c;

  logic [NREQ-1:0] pick_vec;
  logic [IW-1:0]   pick_idx;

  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_byte;
  logic [IW-1:0]   owner_inc;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req  (bus.req_valid),
    .ptr  (rr_ptr),
    .pick (pick_vec),
    .idx  (pick_idx)
  );

  // Mux out the current owner's offer and the pointer value that skips it.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
        owner_byte  = bus.req_data[8*i +: 8];
      end
    end
    owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  // Next-state and output logic. The stall counter only advances while the
  // transmitter is free and the owner has nothing to offer, so a long frame
  // never counts against the owner.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    grant_nxt     = grant_r;
    rr_ptr_nxt    = rr_ptr;
    tx_data_nxt   = tx_data_r;
    tx_start_nxt  = 1'b0;
    last_flag_nxt = last_flag;
    stall_cnt_nxt = stall_cnt;
    wait_cnt_nxt  = wait_cnt;
    timeout_nxt   = 1'b0;
    ready_c       = '0;

    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          owner_nxt     = pick_idx;
          grant_nxt     = pick_vec;
          stall_cnt_nxt = '0;
          state_nxt     = SEND;
        end
      end

      SEND: begin
        if (bus.tx_busy) begin
          state_nxt = SEND;
        end else if (owner_valid) begin
          ready_c       = grant_r;
          tx_data_nxt   = owner_byte;
          tx_start_nxt  = 1'b1;
          last_flag_nxt = owner_last;
          stall_cnt_nxt = '0;
          wait_cnt_nxt  = '0;
          state_nxt     = WAIT_HI;
        end else if (stall_cnt == CW'(TIMEOUT_CYC - 1)) begin
          timeout_nxt   = 1'b1;
          grant_nxt     = '0;
          rr_ptr_nxt    = owner_inc;
          stall_cnt_nxt = '0;
          last_flag_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          stall_cnt_nxt = stall_cnt + 1'b1;
        end
      end

      // Give the transmitter a few cycles to report busy; if it never does,
      // fall through so the arbiter cannot hang on a silent UART.
      WAIT_HI: begin
        if (bus.tx_busy || (wait_cnt == WW'(WAIT_HI_CYC - 1))) begin
          state_nxt = WAIT_LO;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (last_flag) begin
            grant_nxt     = '0;
            rr_ptr_nxt    = owner_inc;
            last_flag_nxt = 1'b0;
            state_nxt     = IDLE;
          end else begin
            stall_cnt_nxt = '0;
            state_nxt     = SEND;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      grant_r    <= '0;
      rr_ptr     <= '0;
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      last_flag  <= 1'b0;
      stall_cnt  <= '0;
      wait_cnt   <= '0;
      timeout_r  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      grant_r    <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      tx_data_r  <= tx_data_nxt;
      tx_start_r <= tx_start_nxt;
      last_flag  <= last_flag_nxt;
      stall_cnt  <= stall_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      timeout_r  <= timeout_nxt;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.grant       = grant_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.tx_start    = tx_start_r;
  assign bus.timeout_err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter: byte-queue requesters, a UART model
// that holds tx_busy for busy_len cycles per frame, and a negedge monitor
// that logs every launched byte, grant episode and strobe.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 40;
  localparam int DEPTH   = 16;
  localparam int LOGN    = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0] src_mem [NREQ][DEPTH];
  int src_wr [NREQ] = '{default: 0};
  int src_rd [NREQ] = '{default: 0};
  logic [NREQ-1:0] rdy_s;

  int busy_len = 8;
  int busy_cnt = 0;

  logic [7:0]      tx_log_data  [LOGN];
  logic [NREQ-1:0] tx_log_grant [LOGN];
  int              tx_log_cyc   [LOGN];
  logic [NREQ-1:0] grant_log    [LOGN];
  int n_tx = 0, n_grant = 0, n_ready = 0, ready_bad = 0, start_busy_bad = 0;
  int n_timeout = 0, timeout_cyc = 0, busy_fall_cyc = 0, valid_rise_cyc = 0;
  logic [NREQ-1:0] timeout_grant = '0;
  logic            prev_busy  = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] prev_valid = '0;

  int tx_base, grant_base, ready_base, ready_bad_base, start_busy_base, timeout_base;

  logic [7:0]      exp_t2_data  [5] = '{8'h11, 8'h12, 8'h13, 8'h31, 8'h32};
  logic [NREQ-1:0] exp_t2_grant [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
  logic [7:0]      exp_t5_data  [4] = '{8'h01, 8'h02, 8'h03, 8'h10};

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: a tx_start launches a frame lasting busy_len cycles.
  always @(posedge clk or posedge reset) begin
    if (reset)
      busy_cnt <= 0;
    else if (bus.tx_start)
      busy_cnt <= busy_len;
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  // Requesters: pop a byte when the arbiter strobed req_ready on the edge,
  // then present the next queued byte just after the edge.
  always @(posedge clk) begin
    rdy_s = bus.req_ready;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy_s[i] && (src_rd[i] != src_wr[i])) src_rd[i] = src_rd[i] + 1;
      if (src_rd[i] != src_wr[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = src_mem[i][src_rd[i] % DEPTH][7:0];
        bus.req_last[i]        = src_mem[i][src_rd[i] % DEPTH][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_start) begin
        if (n_tx < LOGN) begin
          tx_log_data[n_tx]  = bus.tx_data;
          tx_log_grant[n_tx] = bus.grant;
          tx_log_cyc[n_tx]   = cyc;
        end
        if (bus.tx_busy) start_busy_bad++;
        n_tx++;
      end
      if (|bus.req_ready) begin
        n_ready++;
        if (!$onehot(bus.req_ready) || ((bus.req_ready & ~bus.grant) != '0)) ready_bad++;
      end
      if ((bus.grant != '0) && (prev_grant == '0)) begin
        if (n_grant < LOGN) grant_log[n_grant] = bus.grant;
        n_grant++;
      end
      if (bus.timeout_err) begin
        n_timeout++;
        timeout_cyc   = cyc;
        timeout_grant = bus.grant;
      end
      if (prev_busy && !bus.tx_busy) busy_fall_cyc = cyc;
      if ((prev_valid == '0) && (bus.req_valid != '0)) valid_rise_cyc = cyc;
    end
    prev_busy  = bus.tx_busy;
    prev_grant = bus.grant;
    prev_valid = bus.req_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
    src_mem[idx][src_wr[idx] % DEPTH] = {last, data};
    src_wr[idx] = src_wr[idx] + 1;
  endtask

  function automatic logic srcEmpty();
    for (int i = 0; i < NREQ; i++)
      if (src_rd[i] != src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic markBase();
    tx_base         = n_tx;
    grant_base      = n_grant;
    ready_base      = n_ready;
    ready_bad_base  = ready_bad;
    start_busy_base = start_busy_bad;
    timeout_base    = n_timeout;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) src_wr[i] = src_rd[i];
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitQuiet(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while ((quiet < 3) && (n < budget)) begin
      @(negedge clk);
      n++;
      if ((bus.grant == '0) && !bus.tx_busy && srcEmpty()) quiet++;
      else quiet = 0;
    end
    checkOutput({tag, "_settle"}, quiet, 3);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant"},       32'(bus.grant), 0);
    checkOutput({tag, "_req_ready"},   32'(bus.req_ready), 0);
    checkOutput({tag, "_tx_start"},    32'(bus.tx_start), 0);
    checkOutput({tag, "_tx_data"},     32'(bus.tx_data), 0);
    checkOutput({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
    checkOutput({tag, "_rr_ptr"},      32'(dut.rr_ptr), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single requester, two-byte packet.
    $display("[TB] single requester");
    markBase();
    applyStimulus(0, 8'h41, 1'b0);
    applyStimulus(0, 8'h42, 1'b1);
    waitQuiet("t1", 200);
    checkOutput("t1_tx_count", n_tx - tx_base, 2);
    checkOutput("t1_byte0", 32'(tx_log_data[tx_base]), 32'h41);
    checkOutput("t1_byte1", 32'(tx_log_data[tx_base + 1]), 32'h42);
    checkOutput("t1_grant0", 32'(tx_log_grant[tx_base]), 32'b0001);
    checkOutput("t1_latency", tx_log_cyc[tx_base] - valid_rise_cyc, 2);
    checkOutput("t1_grant_idle", 32'(bus.grant), 0);
    checkOutput("t1_rr_ptr", 32'(dut.rr_ptr), 1);
    checkOutput("t1_ready_count", n_ready - ready_base, 2);

    // Contention between req1 and req3 straight out of reset.
    $display("[TB] contention");
    doReset();
    markBase();
    applyStimulus(1, 8'h11, 1'b0);
    applyStimulus(1, 8'h12, 1'b0);
    applyStimulus(1, 8'h13, 1'b1);
    applyStimulus(3, 8'h31, 1'b0);
    applyStimulus(3, 8'h32, 1'b1);
    waitQuiet("t2", 400);
    checkOutput("t2_tx_count", n_tx - tx_base, 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t2_byte%0d", k), 32'(tx_log_data[tx_base + k]), 32'(exp_t2_data[k]));
      checkOutput($sformatf("t2_owner%0d", k), 32'(tx_log_grant[tx_base + k]), 32'(exp_t2_grant[k]));
    end
    checkOutput("t2_grant_episodes", n_grant - grant_base, 2);
    checkOutput("t2_rr_ptr_wrap", 32'(dut.rr_ptr), 0);

    // Fairness: every requester always has a 1-byte packet pending.
    $display("[TB] fairness");
    doReset();
    markBase();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        applyStimulus(i, 8'(8'hA0 + 16 * i + r), 1'b1);
    waitQuiet("t3", 600);
    checkOutput("t3_tx_count", n_tx - tx_base, 8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t3_owner%0d", k), 32'(grant_log[grant_base + k]), 32'(1 << (k % 4)));
      checkOutput($sformatf("t3_byte%0d", k), 32'(tx_log_data[tx_base + k]),
                  32'(8'hA0 + 16 * (k % 4) + (k / 4)));
    end
    checkOutput("t3_rr_ptr", 32'(dut.rr_ptr), 0);

    // Stall: req2 sends a non-last byte and then goes silent.
    $display("[TB] stall timeout");
    doReset();
    markBase();
    applyStimulus(2, 8'h55, 1'b0);
    waitQuiet("t4", 400);
    checkOutput("t4_tx_count", n_tx - tx_base, 1);
    checkOutput("t4_byte", 32'(tx_log_data[tx_base]), 32'h55);
    checkOutput("t4_timeout_pulses", n_timeout - timeout_base, 1);
    checkOutput("t4_timeout_delay", timeout_cyc - busy_fall_cyc, TIMEOUT + 1);
    checkOutput("t4_grant_at_timeout", 32'(timeout_grant), 0);
    checkOutput("t4_rr_ptr", 32'(dut.rr_ptr), 3);

    // Long UART frames.
    $display("[TB] busy stretch");
    busy_len = 260;
    doReset();
    markBase();
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(0, 8'h02, 1'b0);
    applyStimulus(0, 8'h03, 1'b1);
    applyStimulus(1, 8'h10, 1'b1);
    waitQuiet("t5", 3000);
    checkOutput("t5_tx_count", n_tx - tx_base, 4);
    checkOutput("t5_ready_count", n_ready - ready_base, 4);
    checkOutput("t5_start_while_busy", start_busy_bad - start_busy_base, 0);
    checkOutput("t5_ready_bad", ready_bad - ready_bad_base, 0);
    checkOutput("t5_no_timeout", n_timeout - timeout_base, 0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t5_byte%0d", k), 32'(tx_log_data[tx_base + k]), 32'(exp_t5_data[k]));
    busy_len = 8;

    // Reset during WAIT_LO of req1's second byte.
    $display("[TB] reset mid-packet");
    doReset();
    markBase();
    applyStimulus(1, 8'h71, 1'b0);
    applyStimulus(1, 8'h72, 1'b0);
    applyStimulus(1, 8'h73, 1'b1);
    n = 0;
    while (((n_tx - tx_base) < 2) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_second_start", n_tx - tx_base, 2);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    for (int i = 0; i < NREQ; i++) src_wr[i] = src_rd[i];
    markBase();
    repeat (3) @(negedge clk);
    applyStimulus(0, 8'h0A, 1'b1);
    applyStimulus(1, 8'h1A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    waitQuiet("t6", 400);
    checkOutput("t6_tx_count", n_tx - tx_base, 2);
    checkOutput("t6_first_owner", 32'(grant_log[grant_base]), 32'b0001);
    checkOutput("t6_byte0", 32'(tx_log_data[tx_base]), 32'h0A);
    checkOutput("t6_byte1", 32'(tx_log_data[tx_base + 1]), 32'h1A);
    checkOutput("t6_ready_bad", ready_bad - ready_bad_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
